// File: rtl/clk_div_prog.sv
// Purpose : runtime-programmable integer divider of clk50M with a period-start tick; optional 50% duty for odd N (CLK_DIV_ODD_DUTY50_EN).
// Latency : en high -> clk_out/tick high after 1 clk50M edge; a new divisor takes effect at the next period boundary.
// Backpressure: none; div_load is a fire-and-forget strobe into a one-deep pending register (last write wins).
module clk_div_prog #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk50M,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] cur_div,
    output logic             running
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    typedef enum logic {
        S_STOP = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cur_div_q, cur_div_nxt;
    logic [CNT_W-1:0] pend_dat, pend_dat_nxt;
    logic             pend_vld, pend_vld_nxt;
    logic             clk_pos, clk_pos_nxt;
    logic             tick_q, tick_nxt;

    logic [CNT_W-1:0] load_dat;
    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-1:0] high_end;
    logic             do_wrap;

    // Divisors below 2 cannot produce a high and a low phase, so they are raised to 2.
    assign load_dat = (div_val < TWO) ? TWO : div_val;

    // Last count of the period and last count of the high phase (high time is ceil(N/2)).
    assign last_cnt = cur_div_q - ONE;
    assign high_end = cur_div_q - (cur_div_q >> 1) - ONE;

    // State and datapath registers.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_STOP;
            cnt       <= DEF_DIV - ONE;
            cur_div_q <= DEF_DIV;
            pend_dat  <= DEF_DIV;
            pend_vld  <= 1'b0;
            clk_pos   <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cur_div_q <= cur_div_nxt;
            pend_dat  <= pend_dat_nxt;
            pend_vld  <= pend_vld_nxt;
            clk_pos   <= clk_pos_nxt;
            tick_q    <= tick_nxt;
        end
    end

    // Next-state logic: the counter only restarts (and only adopts a pending divisor) at a wrap,
    // so a period in flight always finishes with the divisor it started with.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cur_div_nxt  = cur_div_q;
        pend_dat_nxt = pend_dat;
        pend_vld_nxt = pend_vld;
        clk_pos_nxt  = clk_pos;
        tick_nxt     = 1'b0;
        do_wrap      = 1'b0;

        if (div_load) begin
            pend_dat_nxt = load_dat;
            pend_vld_nxt = 1'b1;
        end

        case (state)
            S_STOP: begin
                clk_pos_nxt = 1'b0;
                cnt_nxt     = last_cnt;
                if (en) begin
                    state_nxt = S_RUN;
                    do_wrap   = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt == last_cnt) begin
                    if (!en) begin
                        // Low phase just completed: park here without starting a new period.
                        state_nxt   = S_STOP;
                        clk_pos_nxt = 1'b0;
                    end else begin
                        do_wrap = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + ONE;
                    if (cnt == high_end) begin
                        clk_pos_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = S_STOP;
            end
        endcase

        if (do_wrap) begin
            cnt_nxt     = '0;
            clk_pos_nxt = 1'b1;
            tick_nxt    = 1'b1;
            // Only the value pending before this edge is consumed; a load in this same
            // cycle has already refreshed pend_dat_nxt and keeps pend_vld set.
            if (pend_vld) begin
                cur_div_nxt = pend_dat;
                if (!div_load) begin
                    pend_vld_nxt = 1'b0;
                end
            end
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic clk_neg;

    // Half-cycle delayed copy of clk_pos; ANDing it in delays only the rising edge.
    always_ff @(negedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            clk_neg <= 1'b0;
        end else begin
            clk_neg <= clk_pos;
        end
    end

    assign clk_out = cur_div_q[0] ? (clk_pos & clk_neg) : clk_pos;
`else
    assign clk_out = clk_pos;
`endif

    assign tick    = tick_q;
    assign cur_div = cur_div_q;
    assign running = (state == S_RUN);

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider clocked from the 50 MHz system clock.
- Produces a divided clock output and a one-cycle period-start tick, for peripheral timing (SPI/I2C/ADC/DAC sample clocks) inside the Qsys subsystems.
- Divisor changes take effect only at period boundaries, so the output never glitches.
- Enable and disable are clean: the output always parks low after a complete period.

Parameters:
- CNT_W, 16, width of the divisor and of the internal counter.
- DEFAULT_DIV, 8, divisor after reset (8 gives 50 MHz -> 6.25 MHz). Must be >= 2.

Ports:
- clk50M  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run request. 1 = run; 0 = stop after the current period ends.
- div_val  in  CNT_W  requested divisor N.
- div_load  in  1  single-cycle strobe; captures div_val into the pending register.
- clk_out  out  1  divided clock.
- tick  out  1  one-cycle pulse in the clk50M cycle where clk_out rises.
- cur_div  out  CNT_W  divisor currently in effect.
- running  out  1  1 while the divider is generating periods.

Behaviour:
- Clock and reset: one clock, clk50M. Reset is asynchronous and active-low on rst_n. All state is in the clk50M domain.
- Reset values: clk_out=0, tick=0, running=0, cur_div=DEFAULT_DIV, cnt=DEFAULT_DIV-1, pending=DEFAULT_DIV, pend_vld=0.
- Divisor clamp: any captured value below 2 (0 or 1) is stored as 2. No other range check.
- Load:
  - div_load=1 writes clamp(div_val) to pending and sets pend_vld.
  - A second load before application overwrites pending (last write wins).
- State STOP (running=0):
  - clk_out=0, cnt=cur_div-1.
  - If en=1, the next edge performs a wrap (see below) and goes to RUN. Latency from en high to clk_out high is 1 cycle.
- State RUN, with N=cur_div, H=N-(N>>1) (high time in cycles), per edge:
  - Case 1, cnt==N-1 (wrap):
    - If en=0: go to STOP, clk_out=0, tick=0.
    - Otherwise: cnt<=0, clk_out<=1, tick<=1. If pend_vld, then cur_div<=pending, pend_vld<=0, and the new N governs this new period.
  - Case 2, cnt==H-1: cnt<=cnt+1, clk_out<=0, tick<=0.
  - Case 3, any other count: cnt<=cnt+1, tick<=0.
- Output waveform:
  - Period = N clk50M cycles.
  - High for ceil(N/2) cycles, low for floor(N/2) cycles.
  - tick is high exactly once per period.
- Stopping: en low mid-period does not truncate the period. The low phase completes, then the divider stops, so there is never a runt pulse.
- Simultaneous div_load and wrap: the value loaded in that cycle is NOT applied at that wrap; it is applied at the following wrap. Wrap consumes the pre-existing pending value.
- Load while in STOP: the value is applied at the restart wrap.
- cur_div: updates in the same cycle as the rising edge of clk_out that begins the new period.
- Reset mid-period: outputs return to reset values immediately, and the pending load is discarded.
- Arithmetic: cnt is CNT_W wide and never exceeds N-1, so no overflow is possible.

Optional Feature:
- Macro: CLK_DIV_ODD_DUTY50_EN.
- Defined:
  - A second flop samples the internal positive-edge clk_out on the falling edge of clk50M.
  - For odd N, the driven output is the AND of the two flops. The rise is delayed by half a cycle and the fall is unchanged, so high time is exactly N/2 clk50M cycles (50% duty).
  - For even N, the output is the positive-edge flop directly.
  - tick, running and cur_div are unaffected.
  - The negative-edge flop resets to 0 on rst_n.
- Not defined: no falling-edge logic. For odd N, high time is ceil(N/2) cycles.

Test Plan:
- Default run: reset, then en=1 from cycle 0.
  - clk_out rises at cycle 1, high 4 cycles, low 4 cycles, period 8.
  - tick pulses every 8 cycles, aligned with each clk_out rise.
- Reprogram: load div_val=5 in the middle of a period.
  - The current 8-cycle period completes.
  - Next period is 5 cycles: high 3, low 2 (macro off); high 2.5 cycles (macro on).
  - cur_div reads 5 from that rise.
- Clamp and overwrite: load 0, then load 3 one cycle later, before the wrap.
  - Next period is 3 cycles.
  - Separately, load 1 alone gives period 2 (high 1, low 1).
- Simultaneous: div_load with div_val=4 on the exact wrap cycle while N=6.
  - The next period is still 6; the one after is 4.
- Stop/start: drop en at cnt=1 with N=8.
  - Output completes the 8-cycle period, then stays low with running=0.
  - Re-raise en: clk_out high after 1 cycle, and tick pulses.
- Async reset: assert rst_n low mid-high-phase with N=10.
  - clk_out drops to 0 immediately, with no clock edge required.
  - cur_div returns to 8 and the pending load is discarded.
